// File: rtl/key_pkg.sv
// Shared definitions for the key conditioner: per-channel FSM encoding and key indices.
// Build option KEY_AUTOREPEAT_EN (see key_debounce_chan) adds auto-repeat press strobes.
package key_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_PLACE = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchronizer, debounce FSM with stability counter, registered strobes.
// With KEY_AUTOREPEAT_EN defined, a repeat counter re-pulses key_press_o while the key stays held.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int STABLE_CNT    = 1000000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o
);

  // Acceptance fires on the cycle the counter would step to STABLE_CNT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 2);

  if ((STABLE_CNT < 2) || (STABLE_CNT > (2 ** CNT_W) - 1) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("key_debounce_chan: parameter out of range");
  end

  logic [1:0]       sync_q, sync_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sample;

  assign sync_d = {sync_q[0], key_raw_i ^ ACTIVE_LOW};
  assign sample = sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_phase_q, rep_phase_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (sample) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sample) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sample) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sample) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

`ifdef KEY_AUTOREPEAT_EN
    rep_d       = '0;
    rep_phase_d = 1'b0;
    // Runs only while the key stays held; any other state restarts the initial delay.
    if ((state_q == ST_HELD) && sample) begin
      rep_phase_d = rep_phase_q;
      if (rep_q == (rep_phase_q ? REP_NEXT : REP_FIRST)) begin
        press_d     = 1'b1;
        rep_d       = '0;
        rep_phase_d = 1'b1;
      end else if (rep_q != '1) begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      state_q   <= ST_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: N_KEYS independent debounce channels packed into vectors.
// KEY_AUTOREPEAT_EN (applied inside each channel) enables auto-repeat press strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS        = 5,
  parameter int CNT_W         = 20,
  parameter int STABLE_CNT    = 1000000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .CNT_W         (CNT_W),
      .STABLE_CNT    (STABLE_CNT),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_raw_i     (key_raw[gi]),
      .key_level_o   (key_level[gi]),
      .key_press_o   (key_press[gi]),
      .key_release_o (key_release[gi])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (2 keys, STABLE_CNT=4, active-low pins, repeat 10/3).
// Define KEY_AUTOREPEAT_EN for both bench and RTL to check the auto-repeat build.
module tb_key_debounce;

  localparam int NK = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int n_cmp = 0;
  int n_bad = 0;

  int press_cnt[NK], rel_cnt[NK], level_cyc[NK], late_press[NK];
  int first_press[NK], second_press[NK], first_rel[NK], first_level[NK];
  int overlap_total = 0;
  int acc;

  key_debounce #(
    .N_KEYS        (NK),
    .CNT_W         (8),
    .STABLE_CNT    (4),
    .ACTIVE_LOW    (1'b1),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step n cycles, tallying strobes/levels per channel; tick index t counts edges since the call.
  task automatic run(input int n);
    for (int c = 0; c < NK; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; level_cyc[c] = 0; late_press[c] = 0;
      first_press[c] = 0; second_press[c] = 0; first_rel[c] = 0; first_level[c] = 0;
    end
    for (int t = 1; t <= n; t++) begin
      tick();
      for (int c = 0; c < NK; c++) begin
        if (key_press[c]) begin
          press_cnt[c]++;
          if (first_press[c] == 0) first_press[c] = t;
          else if (second_press[c] == 0) second_press[c] = t;
          if (t > 2) late_press[c]++;
        end
        if (key_release[c]) begin
          rel_cnt[c]++;
          if (first_rel[c] == 0) first_rel[c] = t;
        end
        if (key_level[c]) begin
          level_cyc[c]++;
          if (first_level[c] == 0) first_level[c] = t;
        end
        if (key_press[c] && key_release[c]) overlap_total++;
      end
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_level", 32'(key_level), 0);
    check_eq("rst_press", 32'(key_press), 0);
    check_eq("rst_release", 32'(key_release), 0);
    rst_n = 1'b1;
    run(3);
    $display("txn reset: level=%b press=%b release=%b", key_level, key_press, key_release);

    // Clean press on key 0
    key_raw[0] = 1'b0;
    run(10);
    $display("txn press0: presses=%0d at %0d", press_cnt[0], first_press[0]);
    check_eq("press_count", press_cnt[0], 1);
    check_eq("press_latency", first_press[0], 6);
    check_eq("press_level_at", first_level[0], 6);
    check_eq("press_no_release", rel_cnt[0], 0);
    check_eq("press_level_end", 32'(key_level[0]), 1);
    check_eq("press_other_chan", press_cnt[1], 0);

    // Release of key 0
    key_raw[0] = 1'b1;
    run(10);
    $display("txn release0: releases=%0d at %0d", rel_cnt[0], first_rel[0]);
    check_eq("rel_count", rel_cnt[0], 1);
    check_eq("rel_latency", first_rel[0], 6);
    check_eq("rel_no_press", press_cnt[0], 0);
    check_eq("rel_level_end", 32'(key_level[0]), 0);

    // Bounce 0,1,0,1 (2 cycles each), then settle pressed
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      key_raw[0] = 1'(i % 2);
      run(2);
      acc += press_cnt[0] + rel_cnt[0] + level_cyc[0];
    end
    check_eq("bounce_quiet", acc, 0);
    key_raw[0] = 1'b0;
    run(10);
    $display("txn bounce0: presses=%0d at %0d", press_cnt[0], first_press[0]);
    check_eq("bounce_press_count", press_cnt[0], 1);
    check_eq("bounce_latency", first_press[0], 6);
    check_eq("bounce_no_release", rel_cnt[0], 0);
    key_raw[0] = 1'b1;
    run(10);

    // Glitch on key 1: low for 3 cycles only
    key_raw[1] = 1'b0;
    run(3);
    acc = press_cnt[1] + rel_cnt[1] + level_cyc[1];
    key_raw[1] = 1'b1;
    run(10);
    acc += press_cnt[1] + rel_cnt[1] + level_cyc[1];
    $display("txn glitch1: activity=%0d", acc);
    check_eq("glitch_quiet", acc, 0);

    // Long hold on key 0
    key_raw[0] = 1'b0;
    run(36);
    $display("txn hold0: presses=%0d first=%0d second=%0d", press_cnt[0], first_press[0], second_press[0]);
    check_eq("hold_first", first_press[0], 6);
`ifdef KEY_AUTOREPEAT_EN
    check_eq("hold_repeat_count", press_cnt[0], 8);
    check_eq("hold_repeat_first", second_press[0], 16);
`else
    check_eq("hold_single_press", press_cnt[0], 1);
    check_eq("hold_no_second", second_press[0], 0);
`endif
    key_raw[0] = 1'b1;
    run(10);
    $display("txn hold_release0: late_presses=%0d release_at=%0d", late_press[0], first_rel[0]);
    check_eq("hold_rel_no_press", late_press[0], 0);
    check_eq("hold_rel_latency", first_rel[0], 6);

    // Reset while key 0 held and key 1 mid-debounce
    key_raw[0] = 1'b0;
    run(8);
    check_eq("pre_rst_level0", 32'(key_level[0]), 1);
    key_raw[1] = 1'b0;
    run(4);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_level", 32'(key_level), 0);
    check_eq("midrst_press", 32'(key_press), 0);
    check_eq("midrst_release", 32'(key_release), 0);
    tick(); tick();
    rst_n = 1'b1;
    run(10);
    $display("txn rst_redetect: p0=%0d@%0d p1=%0d@%0d", press_cnt[0], first_press[0], press_cnt[1], first_press[1]);
    check_eq("redetect0_count", press_cnt[0], 1);
    check_eq("redetect0_latency", first_press[0], 6);
    check_eq("redetect1_count", press_cnt[1], 1);
    check_eq("redetect1_latency", first_press[1], 6);

    check_eq("press_release_overlap", overlap_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
